lsu_rmw: RTL and testbench

- Load/store unit sitting directly upstream of the data RAM (`RAM_golden`) in the RISC-V datapath.
- Accepts RV32I load/store requests from the core: byte address, funct3, store data.
- Drives the RAM's word-only port (`daddr`, `d_rw`, `ddata_w`, `ddata_r`).
- Handles byte/halfword loads with sign/zero extension, sub-word stores by read-modify-write, and misalignment detection.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 39 +++
 rtl/lsu_rmw.sv | 141 ++++++++++++++
 tb/tb_lsu_rmw.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// lane constants and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int              LANE_W    = 2;
  localparam logic [LANE_W-1:0] LANE_WORD = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_t;

  // Unsigned variants exist only for loads; halfwords need even lanes, words lane 0.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [LANE_W-1:0] lane);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != LANE_WORD);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a RAM word and the core: load extract/extend and
// sub-word store merge into the word read back from RAM.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]       rdata_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        funct3_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [31:0]       load_o,
  output logic [31:0]       merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata_i[{lane_i, 3'b000} +: 8];
    half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        load_o  = {{24{byte_v[7]}}, byte_v};
        merge_o = rdata_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_BU: load_o = {24'h0, byte_v};
      F3_H: begin
        load_o  = {{16{half_v[15]}}, half_v};
        merge_o = lane_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                            : {rdata_i[31:16], wdata_i[15:0]};
      end
      F3_HU:   load_o = {16'h0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// RV32I load/store unit in front of a word-only RAM with combinational read.
// Handshake: a request is taken on the edge where req_valid & req_ready; rsp_valid is a one-cycle pulse.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [addr_width-1:0] daddr,
  output logic                  d_rw,
  output logic [data_width-1:0] ddata_w,
  input  logic [data_width-1:0] ddata_r
);

  if (data_width != 32) begin : g_width_check
    $error("lsu_rmw: data_width must be 32");
  end

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   word_q, word_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [2:0]              f3_q, f3_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic                    err_pend_q, err_pend_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic [31:0]             load_val, merge_val;
  logic                    accept;
  logic                    unused_addr;

  // Addresses wrap: bits above the RAM word index are intentionally ignored.
  assign unused_addr = ^req_addr[31:addr_width+2];

  lsu_align u_align (
    .rdata_i  (ddata_r),
    .wdata_i  (wdata_q),
    .funct3_i (f3_q),
    .lane_i   (lane_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    err_pend_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
            err_pend_d = 1'b1;
          end else begin
            word_d  = req_addr[addr_width+1:2];
            lane_d  = req_addr[1:0];
            f3_d    = req_funct3;
            wdata_d = req_wdata;
            if (!req_we)                 state_d = S_LOAD;
            else if (req_funct3 == F3_W) state_d = S_STORE;
            else                         state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_val;
        state_d     = S_IDLE;
      end
      S_STORE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_RMW_RD: begin
        wdata_d = merge_val;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A pending error only exists while idle, so it never collides with another response.
    if (err_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      err_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      err_pend_q  <= err_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign daddr     = word_q;
  assign d_rw      = (state_q == S_STORE) || (state_q == S_RMW_WR);
  assign ddata_w   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: RAM model, transaction-level reference model with a
// per-cycle compare, and directed requests with hand-computed results.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  daddr;
  logic        d_rw;
  logic [31:0] ddata_w, ddata_r;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_rmw #(.addr_width(10), .data_width(32)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .daddr(daddr), .d_rw(d_rw), .ddata_w(ddata_w), .ddata_r(ddata_r)
  );

  // ---------------- RAM ----------------
  logic [31:0] mem [1024] = '{default: 32'h0};
  assign ddata_r = mem[daddr];
  always @(posedge clk) if (d_rw) mem[daddr] <= ddata_w;

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  word;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic        err;
    int          due;
  } req_t;

  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  req_t        pend_q[$];
  logic [32:0] exp_q[$];
  int          edge_n = 0;
  int          busy_edge = 0;
  logic        due_now = 1'b0;

  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [31:0] s;
    s = w >> (8 * int'(lane));
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    sh   = 8 * int'(lane);
    mask = (f3 == 3'b000) ? 32'hFF : (f3 == 3'b001) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  initial begin : model
    req_t cur;
    int   lat;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend_q.delete();
        exp_q.delete();
        busy_edge = edge_n;
        due_now   = 1'b0;
      end else begin
        edge_n++;
        due_now = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
          cur     = pend_q.pop_front();
          due_now = 1'b1;
          if (cur.err)      exp_q.push_back({1'b1, 32'h0});
          else if (!cur.we) exp_q.push_back({1'b0, m_load(ref_mem[cur.word], cur.f3, cur.lane)});
          else begin
            ref_mem[cur.word] = m_store(ref_mem[cur.word], cur.f3, cur.lane, cur.wdata);
            exp_q.push_back({1'b0, 32'h0});
          end
        end
        if (req_valid && (edge_n - 1) >= busy_edge) begin
          cur.we    = req_we;
          cur.f3    = req_funct3;
          cur.word  = req_addr[11:2];
          cur.lane  = req_addr[1:0];
          cur.wdata = req_wdata;
          cur.err   = m_err(req_we, req_funct3, req_addr);
          lat       = (!cur.err && req_we && req_funct3 != 3'b010) ? 2 : 1;
          cur.due   = edge_n + lat;
          if (!cur.err) busy_edge = cur.due;
          pend_q.push_back(cur);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [32:0] e_rsp;
  logic        exp_wr;
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(edge_n >= busy_edge));
      chk("rsp_valid", 32'(rsp_valid), 32'(due_now));
      if (due_now) begin
        if (exp_q.size() > 0) begin
          e_rsp = exp_q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e_rsp[32]));
          chk("rsp_rdata", rsp_rdata, e_rsp[31:0]);
        end else begin
          n_checks++; n_fail++;
          $display("FAIL exp_q_empty: response expected with no queued value");
        end
      end
      exp_wr = (pend_q.size() > 0) && !pend_q[0].err && pend_q[0].we && (pend_q[0].due == edge_n + 1);
      chk("d_rw", 32'(d_rw), 32'(exp_wr));
      if (exp_wr) begin
        chk("daddr", 32'(daddr), 32'(pend_q[0].word));
        chk("ddata_w", ddata_w,
            m_store(ref_mem[pend_q[0].word], pend_q[0].f3, pend_q[0].lane, pend_q[0].wdata));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_rsp(input string name, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!rsp_valid && k < 10);
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", name, k);
    end else begin
      chk({name, "_lat"}, 32'(k), 32'(exp_lat));
      chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
      chk({name, "_rdata"}, rsp_rdata, exp_rd);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_daddr", 32'(daddr), 32'h0);
    chk("rst_d_rw", 32'(d_rw), 32'h0);
    chk("rst_ddata_w", ddata_w, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // full-word store, RAM port values in the write cycle
    send(1'b1, 3'b010, 32'h008, 32'hDEADBEEF);
    chk("sw_d_rw", 32'(d_rw), 32'h1);
    chk("sw_daddr", 32'(daddr), 32'h2);
    chk("sw_ddata_w", ddata_w, 32'hDEADBEEF);
    wait_rsp("sw", 1, 1'b0, 32'h0);
    chk("sw_d_rw_drop", 32'(d_rw), 32'h0);
    chk("sw_mem", mem[2], 32'hDEADBEEF);

    send(1'b0, 3'b010, 32'h008, 32'h0);  wait_rsp("lw",  1, 1'b0, 32'hDEADBEEF);
    send(1'b0, 3'b000, 32'h009, 32'h0);  wait_rsp("lb",  1, 1'b0, 32'hFFFFFFBE);
    send(1'b0, 3'b100, 32'h009, 32'h0);  wait_rsp("lbu", 1, 1'b0, 32'h000000BE);
    send(1'b0, 3'b001, 32'h00A, 32'h0);  wait_rsp("lh",  1, 1'b0, 32'hFFFFDEAD);
    send(1'b0, 3'b101, 32'h00A, 32'h0);  wait_rsp("lhu", 1, 1'b0, 32'h0000DEAD);

    // sub-word stores via read-modify-write
    send(1'b1, 3'b000, 32'h00B, 32'h00000012);
    chk("sb_rd_d_rw", 32'(d_rw), 32'h0);
    wait_rsp("sb", 2, 1'b0, 32'h0);
    chk("sb_mem", mem[2], 32'h12ADBEEF);
    send(1'b1, 3'b001, 32'h008, 32'h00005566);
    wait_rsp("sh", 2, 1'b0, 32'h0);
    chk("sh_mem", mem[2], 32'h12AD5566);
    send(1'b0, 3'b000, 32'h00F, 32'h0);  wait_rsp("lb_zero", 1, 1'b0, 32'h0);

    // errors: no RAM access
    send(1'b0, 3'b010, 32'h006, 32'h0);      wait_rsp("lw_mis",  1, 1'b1, 32'h0);
    send(1'b1, 3'b001, 32'h009, 32'hFFFF);   wait_rsp("sh_mis",  1, 1'b1, 32'h0);
    send(1'b0, 3'b011, 32'h008, 32'h0);      wait_rsp("f3_011",  1, 1'b1, 32'h0);
    send(1'b1, 3'b100, 32'h008, 32'h0);      wait_rsp("sbu_bad", 1, 1'b1, 32'h0);
    chk("err_mem", mem[2], 32'h12AD5566);

    // reset while the merged word is being written
    send(1'b1, 3'b000, 32'h004, 32'h000000A5);
    @(posedge clk); #1;
    chk("rmw_wr_d_rw", 32'(d_rw), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_d_rw", 32'(d_rw), 32'h0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_mem", mem[1], 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_no_rsp", 32'(rsp_valid), 32'h0);

    // back-to-back with wrapped address
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h1008; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("b2b_busy_ready", 32'(req_ready), 32'h0);
    chk("b2b_sw_daddr", 32'(daddr), 32'h2);
    req_we = 1'b0; req_addr = 32'h008; req_wdata = 32'h0;
    @(posedge clk); #1;
    chk("b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("b2b_rsp1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_lw_daddr", 32'(daddr), 32'h2);
    @(posedge clk); #1;
    chk("b2b_lw_valid", 32'(rsp_valid), 32'h1);
    chk("b2b_lw_rdata", rsp_rdata, 32'h0BADF00D);
    chk("b2b_mem", mem[2], 32'h0BADF00D);

    repeat (4) @(posedge clk);
    #1;
    chk("final_pend_empty", 32'(pend_q.size()), 32'h0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
